// File: rtl/lsu_bus_master_pkg.sv
// Shared definitions for the LSU bus master: funct3 codes, FSM states, bus command payload
// and the access legality check.
package lsu_bus_master_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned BE_W = XLEN / 8;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } lsu_state_e;

  typedef struct packed {
    logic            we;
    logic [XLEN-1:0] addr;
    logic [BE_W-1:0] be;
    logic [XLEN-1:0] wdata;
  } bus_cmd_t;

  // Misaligned halfword/word, reserved funct3, or an unsigned-size store.
  function automatic logic access_illegal(input logic       we,
                                          input logic [2:0] funct3,
                                          input logic [1:0] addr_lo);
    logic ill;
    ill = 1'b0;
    case (funct3)
      F3_B:    ill = 1'b0;
      F3_H:    ill = addr_lo[0];
      F3_W:    ill = (addr_lo != 2'b00);
      F3_BU:   ill = we;
      F3_HU:   ill = we | addr_lo[0];
      default: ill = 1'b1;
    endcase
    return ill;
  endfunction

endpackage

// File: rtl/lsu_bus_master_align.sv
// Combinational lane steering: store byte enables / replicated store data and load
// extraction with sign or zero extension.
module lsu_data_align
  import lsu_bus_master_pkg::*;
(
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] wdata,
  input  logic [XLEN-1:0] rdata,
  output logic [BE_W-1:0] be,
  output logic [XLEN-1:0] wdata_aligned,
  output logic [XLEN-1:0] rdata_ext
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rdata[{addr_lo, 3'b000} +: 8];
  assign half_sel = rdata[{addr_lo[1], 4'b0000} +: 16];

  // Store side: size comes from funct3[1:0]; lanes are replicated so be alone selects.
  always_comb begin
    be            = '0;
    wdata_aligned = '0;
    case (funct3[1:0])
      2'b00: begin
        be            = 4'b0001 << addr_lo;
        wdata_aligned = {4{wdata[7:0]}};
      end
      2'b01: begin
        be            = 4'b0011 << {addr_lo[1], 1'b0};
        wdata_aligned = {2{wdata[15:0]}};
      end
      2'b10: begin
        be            = 4'b1111;
        wdata_aligned = wdata;
      end
      default: begin
        be            = '0;
        wdata_aligned = '0;
      end
    endcase
  end

  always_comb begin
    rdata_ext = '0;
    case (funct3)
      F3_B:    rdata_ext = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    rdata_ext = {{16{half_sel[15]}}, half_sel};
      F3_W:    rdata_ext = rdata;
      F3_BU:   rdata_ext = {24'h000000, byte_sel};
      F3_HU:   rdata_ext = {16'h0000, half_sel};
      default: rdata_ext = '0;
    endcase
  end

endmodule

// File: rtl/lsu_bus_master.sv
// Data-memory initiator: one load/store at a time over a req/gnt/rvalid word bus,
// with alignment checking and a responder timeout.
module lsu_bus_master
  import lsu_bus_master_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            rsp_valid,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_misalign,
  output logic            rsp_timeout,
  output logic            bus_req,
  input  logic            bus_gnt,
  output logic            bus_we,
  output logic [XLEN-1:0] bus_addr,
  output logic [BE_W-1:0] bus_be,
  output logic [XLEN-1:0] bus_wdata,
  input  logic            bus_rvalid,
  input  logic [XLEN-1:0] bus_rdata
);

  localparam int unsigned     CNT_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  lsu_state_e      state_q, state_n;
  bus_cmd_t        cmd_q, cmd_n;
  logic            bus_req_q, bus_req_n;
  logic            rsp_valid_q, rsp_valid_n;
  logic [XLEN-1:0] rsp_rdata_q, rsp_rdata_n;
  logic            rsp_misalign_q, rsp_misalign_n;
  logic            rsp_timeout_q, rsp_timeout_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic [2:0]      lat_funct3_q, lat_funct3_n;
  logic [1:0]      lat_addr_lo_q, lat_addr_lo_n;

  logic            idle;
  logic [2:0]      al_funct3;
  logic [1:0]      al_addr_lo;
  logic [BE_W-1:0] al_be;
  logic [XLEN-1:0] al_wdata;
  logic [XLEN-1:0] al_rdata;

  assign idle       = (state_q == ST_IDLE);
  // In IDLE the aligner formats the incoming request; afterwards it formats the read word.
  assign al_funct3  = idle ? req_funct3    : lat_funct3_q;
  assign al_addr_lo = idle ? req_addr[1:0] : lat_addr_lo_q;

  lsu_data_align u_align (
    .funct3        (al_funct3),
    .addr_lo       (al_addr_lo),
    .wdata         (req_wdata),
    .rdata         (bus_rdata),
    .be            (al_be),
    .wdata_aligned (al_wdata),
    .rdata_ext     (al_rdata)
  );

  always_comb begin
    state_n        = state_q;
    cmd_n          = cmd_q;
    bus_req_n      = bus_req_q;
    cnt_n          = cnt_q;
    lat_funct3_n   = lat_funct3_q;
    lat_addr_lo_n  = lat_addr_lo_q;
    rsp_valid_n    = 1'b0;
    rsp_rdata_n    = '0;
    rsp_misalign_n = 1'b0;
    rsp_timeout_n  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          lat_funct3_n  = req_funct3;
          lat_addr_lo_n = req_addr[1:0];
          if (access_illegal(req_we, req_funct3, req_addr[1:0])) begin
            state_n        = ST_RESP;
            rsp_valid_n    = 1'b1;
            rsp_misalign_n = 1'b1;
          end else begin
            state_n     = ST_REQ;
            bus_req_n   = 1'b1;
            cmd_n.we    = req_we;
            cmd_n.addr  = {req_addr[XLEN-1:2], 2'b00};
            cmd_n.be    = req_we ? al_be : 4'b1111;
            cmd_n.wdata = req_we ? al_wdata : '0;
          end
        end
      end
      ST_REQ: begin
        if (bus_gnt) begin
          state_n   = ST_WAIT;
          bus_req_n = 1'b0;
          cnt_n     = '0;
        end
      end
      ST_WAIT: begin
        cnt_n = cnt_q + CNT_W'(1);
        if (bus_rvalid) begin
          state_n     = ST_RESP;
          rsp_valid_n = 1'b1;
          rsp_rdata_n = cmd_q.we ? '0 : al_rdata;
        end else if (cnt_q == CNT_LAST) begin
          state_n       = ST_RESP;
          rsp_valid_n   = 1'b1;
          rsp_timeout_n = 1'b1;
        end
      end
      ST_RESP: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      cmd_q          <= '0;
      bus_req_q      <= 1'b0;
      cnt_q          <= '0;
      lat_funct3_q   <= '0;
      lat_addr_lo_q  <= '0;
      rsp_valid_q    <= 1'b0;
      rsp_rdata_q    <= '0;
      rsp_misalign_q <= 1'b0;
      rsp_timeout_q  <= 1'b0;
    end else begin
      state_q        <= state_n;
      cmd_q          <= cmd_n;
      bus_req_q      <= bus_req_n;
      cnt_q          <= cnt_n;
      lat_funct3_q   <= lat_funct3_n;
      lat_addr_lo_q  <= lat_addr_lo_n;
      rsp_valid_q    <= rsp_valid_n;
      rsp_rdata_q    <= rsp_rdata_n;
      rsp_misalign_q <= rsp_misalign_n;
      rsp_timeout_q  <= rsp_timeout_n;
    end
  end

  assign req_ready    = idle;
  assign bus_req      = bus_req_q;
  assign bus_we       = cmd_q.we;
  assign bus_addr     = cmd_q.addr;
  assign bus_be       = cmd_q.be;
  assign bus_wdata    = cmd_q.wdata;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_rdata    = rsp_rdata_q;
  assign rsp_misalign = rsp_misalign_q;
  assign rsp_timeout  = rsp_timeout_q;

endmodule
